// File: rtl/uart_core_param_if.sv
// Handshake bundle between the bus register block and uart_core_param:
// TX word handshake, RX word handshake with per-word flags, and busy/overrun status.
interface uart_core_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_parity_err;
  logic              rx_frame_err;
  logic              rx_overrun;
  logic              rx_busy;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun, rx_busy
  );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART with runtime baud divisor and per-frame error flags.
// Define UART_RX_FIFO_EN to replace the single RX holding register with an RX_FIFO_DEPTH-entry FIFO.
module uart_core_param #(
  parameter int DATA_W        = 8,
  parameter int PARITY        = 1,
  parameter int STOP_BITS     = 1,
  parameter int OVERSAMPLE    = 16,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       baud_div,
  uart_core_param_if.slave  bus,
  input  logic              RX,
  output logic              TX
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_W - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  generate
    if (DATA_W < 5 || DATA_W > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || RX_FIFO_DEPTH < 2 ||
        (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_core_param: unsupported parameter combination");
    end
  endgenerate

  logic [15:0] div_last;
  assign div_last = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;

  // Shared oversampling tick; '>=' keeps it recovering if baud_div shrinks mid-count.
  logic [15:0] tick_cnt_reg;
  logic        os_tick;
  assign os_tick = (tick_cnt_reg >= div_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_reg <= '0;
    else     tick_cnt_reg <= os_tick ? 16'd0 : tick_cnt_reg + 16'd1;
  end

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t         tx_state_reg, tx_state_next;
  logic [15:0]       tx_div_reg, tx_div_next;
  logic [OS_W-1:0]   tx_os_reg, tx_os_next;
  logic [3:0]        tx_bit_reg, tx_bit_next;
  logic [DATA_W-1:0] tx_shift_reg, tx_shift_next;
  logic              tx_par_reg, tx_par_next;
  logic              tx_line_reg, tx_line_next;
  logic              tx_bit_end;

  // TX keeps its own sub-tick phase, cleared at accept, so every bit is exactly baud_div*OVERSAMPLE clk.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_div_next   = tx_div_reg;
    tx_os_next    = tx_os_reg;
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    tx_par_next   = tx_par_reg;
    tx_line_next  = tx_line_reg;
    tx_bit_end    = 1'b0;
    if (tx_state_reg != TX_IDLE) begin
      if (tx_div_reg >= div_last) begin
        tx_div_next = '0;
        if (tx_os_reg == OS_LAST) begin
          tx_os_next = '0;
          tx_bit_end = 1'b1;
        end else begin
          tx_os_next = tx_os_reg + OS_W'(1);
        end
      end else begin
        tx_div_next = tx_div_reg + 16'd1;
      end
    end
    case (tx_state_reg)
      TX_IDLE: begin
        tx_line_next = 1'b1;
        if (bus.tx_valid) begin
          tx_state_next = TX_START;
          tx_shift_next = bus.tx_data;
          tx_par_next   = (PARITY == 2) ? ~^bus.tx_data : ^bus.tx_data;
          tx_line_next  = 1'b0;
          tx_div_next   = '0;
          tx_os_next    = '0;
          tx_bit_next   = '0;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_next = TX_DATA;
        tx_line_next  = tx_shift_reg[0];
        tx_shift_next = tx_shift_reg >> 1;
        tx_bit_next   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        if (tx_bit_reg == DATA_LAST) begin
          tx_bit_next = '0;
          if (PARITY != 0) begin
            tx_state_next = TX_PARITY;
            tx_line_next  = tx_par_reg;
          end else begin
            tx_state_next = TX_STOP;
            tx_line_next  = 1'b1;
          end
        end else begin
          tx_line_next  = tx_shift_reg[0];
          tx_shift_next = tx_shift_reg >> 1;
          tx_bit_next   = tx_bit_reg + 4'd1;
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_next = TX_STOP;
        tx_line_next  = 1'b1;
        tx_bit_next   = '0;
      end
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit_reg == STOP_LAST) tx_state_next = TX_IDLE;
        else                         tx_bit_next   = tx_bit_reg + 4'd1;
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_div_reg   <= '0;
      tx_os_reg    <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_line_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_div_reg   <= tx_div_next;
      tx_os_reg    <= tx_os_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      tx_par_reg   <= tx_par_next;
      tx_line_reg  <= tx_line_next;
    end
  end

  assign TX           = tx_line_reg;
  assign bus.tx_ready = (tx_state_reg == TX_IDLE);
  assign bus.tx_busy  = (tx_state_reg != TX_IDLE);

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  rx_state_t         rx_state_reg, rx_state_next;
  logic              rx_meta_reg, rx_sync_reg;
  logic [OS_W-1:0]   rx_os_reg, rx_os_next;
  logic [3:0]        rx_bit_reg, rx_bit_next;
  logic [DATA_W-1:0] rx_shift_reg, rx_shift_next;
  logic              rx_perr_reg, rx_perr_next;
  logic              rx_ferr_reg, rx_ferr_next;
  logic              rx_push, rx_push_ferr;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_os_next    = rx_os_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_perr_next  = rx_perr_reg;
    rx_ferr_next  = rx_ferr_reg;
    rx_push       = 1'b0;
    rx_push_ferr  = rx_ferr_reg | ~rx_sync_reg;
    case (rx_state_reg)
      RX_IDLE: if (!rx_sync_reg) begin
        rx_state_next = RX_START;
        rx_os_next    = '0;
      end
      RX_START: if (os_tick) begin
        if (rx_os_reg == OS_HALF) begin
          rx_os_next = '0;
          if (!rx_sync_reg) begin
            rx_state_next = RX_DATA;
            rx_bit_next   = '0;
            rx_perr_next  = 1'b0;
            rx_ferr_next  = 1'b0;
          end else begin
            rx_state_next = RX_IDLE;
          end
        end else begin
          rx_os_next = rx_os_reg + OS_W'(1);
        end
      end
      RX_DATA: if (os_tick) begin
        if (rx_os_reg == OS_LAST) begin
          rx_os_next    = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[DATA_W-1:1]};
          if (rx_bit_reg == DATA_LAST) begin
            rx_bit_next   = '0;
            rx_state_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + 4'd1;
          end
        end else begin
          rx_os_next = rx_os_reg + OS_W'(1);
        end
      end
      RX_PARITY: if (os_tick) begin
        if (rx_os_reg == OS_LAST) begin
          rx_os_next    = '0;
          rx_bit_next   = '0;
          rx_perr_next  = (^rx_shift_reg) ^ rx_sync_reg ^ (PARITY == 2);
          rx_state_next = RX_STOP;
        end else begin
          rx_os_next = rx_os_reg + OS_W'(1);
        end
      end
      RX_STOP: if (os_tick) begin
        if (rx_os_reg == OS_LAST) begin
          rx_os_next = '0;
          if (!rx_sync_reg) rx_ferr_next = 1'b1;
          if (rx_bit_reg == STOP_LAST) begin
            rx_state_next = RX_IDLE;
            rx_push       = 1'b1;
          end else begin
            rx_bit_next = rx_bit_reg + 4'd1;
          end
        end else begin
          rx_os_next = rx_os_reg + OS_W'(1);
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_os_reg    <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_perr_reg  <= 1'b0;
      rx_ferr_reg  <= 1'b0;
    end else begin
      rx_meta_reg  <= RX;
      rx_sync_reg  <= rx_meta_reg;
      rx_state_reg <= rx_state_next;
      rx_os_reg    <= rx_os_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_perr_reg  <= rx_perr_next;
      rx_ferr_reg  <= rx_ferr_next;
    end
  end

  assign bus.rx_busy = (rx_state_reg != RX_IDLE);

  // ---------------- RX output buffer ----------------
  logic rx_overrun_reg, rx_overrun_next;

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [DATA_W+1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]       count_reg;
  logic [DATA_W+1:0] head;
  logic              full, empty, pop, push_ok;

  assign full    = (count_reg == (AW+1)'(RX_FIFO_DEPTH));
  assign empty   = (count_reg == '0);
  assign pop     = !empty && bus.rx_ready;
  assign push_ok = rx_push && (!full || pop);
  assign head    = fifo_mem[rd_ptr_reg];
  assign rx_overrun_next = rx_push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= {rx_shift_reg, rx_perr_reg, rx_push_ferr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop);
    end
  end

  // Storage is not reset, so outputs are masked while empty to present zeros after reset.
  assign bus.rx_valid      = !empty;
  assign bus.rx_data       = empty ? '0 : head[DATA_W+1:2];
  assign bus.rx_parity_err = !empty && head[1];
  assign bus.rx_frame_err  = !empty && head[0];
`else
  logic              hold_valid_reg;
  logic [DATA_W-1:0] hold_data_reg;
  logic              hold_perr_reg, hold_ferr_reg;
  logic              pop, push_ok;

  assign pop     = hold_valid_reg && bus.rx_ready;
  assign push_ok = rx_push && (!hold_valid_reg || pop);
  assign rx_overrun_next = rx_push && hold_valid_reg && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
      hold_perr_reg  <= 1'b0;
      hold_ferr_reg  <= 1'b0;
    end else if (push_ok) begin
      hold_valid_reg <= 1'b1;
      hold_data_reg  <= rx_shift_reg;
      hold_perr_reg  <= rx_perr_reg;
      hold_ferr_reg  <= rx_push_ferr;
    end else if (pop) begin
      hold_valid_reg <= 1'b0;
    end
  end

  assign bus.rx_valid      = hold_valid_reg;
  assign bus.rx_data       = hold_data_reg;
  assign bus.rx_parity_err = hold_valid_reg && hold_perr_reg;
  assign bus.rx_frame_err  = hold_valid_reg && hold_ferr_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_overrun_reg <= 1'b0;
    else     rx_overrun_reg <= rx_overrun_next;
  end

  assign bus.rx_overrun = rx_overrun_reg;

endmodule

// File: tb/tb_uart_core_param.sv
// Scoreboard bench for uart_core_param: random loopback frames, bit-banged error/glitch frames,
// overrun with a stalled consumer, and reset in the middle of a frame.
`timescale 1ns/1ps
module tb_uart_core_param;
  localparam int DATA_W = 8;
`ifdef UART_RX_FIFO_EN
  localparam int BUF_DEPTH = 4;
`else
  localparam int BUF_DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        rx_pin, tx_pin;
  logic        loop_en = 1'b1;
  logic        bench_rx = 1'b1;
  bit          hold_ready = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          ovr_seen = 0;
  logic [9:0]  exp_q [$];
  logic [9:0]  mon_e;

  uart_core_param_if #(.DATA_W(DATA_W)) bus_if ();

  uart_core_param #(
    .DATA_W(DATA_W), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .RX_FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .bus(bus_if), .RX(rx_pin), .TX(tx_pin)
  );

  assign rx_pin = loop_en ? tx_pin : bench_rx;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer: random back-pressure unless a test stalls it.
  initial begin
    bus_if.rx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.rx_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: a handshake seen on the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus_if.rx_valid === 1'b1 && bus_if.rx_ready === 1'b1) begin
      $display("rx 0x%02h perr=%0b ferr=%0b", bus_if.rx_data, bus_if.rx_parity_err, bus_if.rx_frame_err);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rx_unexpected: got frame 0x%02h, expected no frame", bus_if.rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rx_data", 32'(bus_if.rx_data), 32'(mon_e[9:2]));
        check("rx_parity_err", 32'(bus_if.rx_parity_err), 32'(mon_e[1]));
        check("rx_frame_err", 32'(bus_if.rx_frame_err), 32'(mon_e[0]));
      end
    end
    if (bus_if.rx_overrun === 1'b1) ovr_seen++;
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends one word through the transmitter and checks every bit mid-period plus tx_ready timing.
  task automatic send(input logic [7:0] d);
    bit [10:0] bits;
    int budget;
    bits = {1'b1, ^d, d, 1'b0};
    budget = 0;
    @(negedge clk);
    bus_if.tx_data  = d;
    bus_if.tx_valid = 1'b1;
    while (bus_if.tx_ready !== 1'b1 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    if (bus_if.tx_ready !== 1'b1) begin
      check("tx_accept", 32'(bus_if.tx_ready), 32'd1);
      bus_if.tx_valid = 1'b0;
      return;
    end
    exp_q.push_back({d, 2'b00});
    $display("tx 0x%02h", d);
    @(posedge clk);
    #1 bus_if.tx_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      repeat ((i == 0) ? 32 : 64) @(posedge clk);
      #2 check($sformatf("tx_bit%0d", i), 32'(tx_pin), 32'(bits[i]));
    end
    repeat (31) @(posedge clk);
    #2;
    check("tx_ready_last_stop", 32'(bus_if.tx_ready), 32'd0);
    check("tx_busy_last_stop", 32'(bus_if.tx_busy), 32'd1);
    @(posedge clk);
    #2 check("tx_ready_after_frame", 32'(bus_if.tx_ready), 32'd1);
  endtask

  // Bit-bangs a frame onto RX; a bad stop bit is held low only 48 clk so the tail is not a new start.
  task automatic drive_frame(input logic [7:0] d, input bit par, input bit stop_ok, input bit expect_rx);
    if (expect_rx) exp_q.push_back({d, par != (^d), !stop_ok});
    $display("drive 0x%02h par=%0b stop=%0b", d, par, stop_ok);
    @(posedge clk);
    #1 bench_rx = 1'b0;
    hold(64);
    for (int i = 0; i < 8; i++) begin
      bench_rx = d[i];
      hold(64);
    end
    bench_rx = par;
    hold(64);
    if (stop_ok) begin
      bench_rx = 1'b1;
      hold(64);
    end else begin
      bench_rx = 1'b0;
      hold(48);
      bench_rx = 1'b1;
      hold(16);
    end
    hold(64);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int budget;
    logic [7:0] d;
    bus_if.tx_data  = '0;
    bus_if.tx_valid = 1'b0;
    hold(5);
    check("rst_TX", 32'(tx_pin), 32'd1);
    check("rst_tx_ready", 32'(bus_if.tx_ready), 32'd1);
    check("rst_tx_busy", 32'(bus_if.tx_busy), 32'd0);
    check("rst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus_if.rx_data), 32'd0);
    check("rst_parity_err", 32'(bus_if.rx_parity_err), 32'd0);
    check("rst_frame_err", 32'(bus_if.rx_frame_err), 32'd0);
    check("rst_overrun", 32'(bus_if.rx_overrun), 32'd0);
    check("rst_rx_busy", 32'(bus_if.rx_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold(10);

    // Loopback, back-to-back frames, first one the 0xA5 reference frame.
    loop_en = 1'b1;
    send(8'hA5);
    send(8'h3C);
    send(8'hC3);
    for (int k = 0; k < 5; k++) send(8'($urandom));
    wait_drain();

    // Direct drive: parity and framing errors, then random error injection.
    loop_en = 1'b0;
    bench_rx = 1'b1;
    hold(10);
    drive_frame(8'h01, 1'b0, 1'b1, 1'b1);
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      drive_frame(d, (^d) ^ 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    wait_drain();

    // Short low glitch must be rejected without a frame.
    @(posedge clk);
    #1 bench_rx = 1'b0;
    hold(20);
    bench_rx = 1'b1;
    hold(60);
    check("glitch_rx_busy", 32'(bus_if.rx_busy), 32'd0);
    check("glitch_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    drive_frame(8'h96, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // Stalled consumer: one frame more than the buffer holds.
    hold_ready = 1'b1;
    hold(2);
    base = ovr_seen;
    for (int k = 0; k <= BUF_DEPTH; k++) begin
      drive_frame(8'((k + 1) * 17), ^(8'((k + 1) * 17)), 1'b1, k < BUF_DEPTH);
    end
    hold(10);
    check("overrun_pulses", 32'(ovr_seen - base), 32'd1);
    check("overrun_hold_valid", 32'(bus_if.rx_valid), 32'd1);
    check("overrun_hold_data", 32'(bus_if.rx_data), 32'h11);
    hold_ready = 1'b0;
    wait_drain();

    // Reset in the middle of a looped-back frame.
    loop_en = 1'b1;
    hold(10);
    @(negedge clk);
    bus_if.tx_data  = 8'hE7;
    bus_if.tx_valid = 1'b1;
    budget = 0;
    while (bus_if.tx_ready !== 1'b1 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    #1 bus_if.tx_valid = 1'b0;
    repeat (300) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_TX", 32'(tx_pin), 32'd1);
    check("midrst_tx_ready", 32'(bus_if.tx_ready), 32'd1);
    check("midrst_rx_busy", 32'(bus_if.rx_busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hold(2);
    check("postrst_tx_ready", 32'(bus_if.tx_ready), 32'd1);
    check("postrst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    check("postrst_TX", 32'(tx_pin), 32'd1);
    send(8'($urandom));
    wait_drain();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
